// File: rtl/cpu_types_pkg.sv
// Shared types for the memory-side arbiter: RAM status, controller FSM
// states, requester IDs and word types.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] addr_t;
    typedef logic [WORD_W-1:0] data_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IFETCH = 3'd1,
        DREAD  = 3'd2,
        DWRITE = 3'd3,
        RETRY  = 3'd4,
        RESP   = 3'd5
    } memctl_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: data over instruction, optionally
// overridden by the starvation count when ARB_FAIR_EN is defined.
module mem_arb_pick
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int STARVE_W   = 3
) (
    input  logic                i_iren,
    input  logic                i_dren,
    input  logic                i_dwen,
    input  logic [STARVE_W-1:0] i_starve,
    output logic                o_valid,
    output req_id_t             o_id,
    output logic                o_write
);

    logic w_force;

`ifdef ARB_FAIR_EN
    assign w_force = i_iren && (i_starve == STARVE_W'(STARVE_MAX));
`else
    logic w_unused;
    assign w_unused = ^i_starve;
    assign w_force  = 1'b0;
`endif

    always_comb begin
        o_valid = i_iren | i_dren | i_dwen;
        o_id    = REQ_I;
        o_write = 1'b0;
        priority case (1'b1)
            w_force: begin
                o_id    = REQ_I;
                o_write = 1'b0;
            end
            (i_dwen | i_dren): begin
                // both strobes together is illegal; it resolves to a write
                o_id    = REQ_D;
                o_write = i_dwen;
            end
            default: begin
                o_id    = REQ_I;
                o_write = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Memory-side responder for the I/D cache pair: one RAM transaction at a
// time, error retry, wait handshakes. Fairness counter under ARB_FAIR_EN.
module mem_arbiter_ctrl
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              busy
);

    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    memctl_state_t     r_state;
    memctl_state_t     r_acc;
    memctl_state_t     w_next;
    req_id_t           r_req;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_store;
    logic [DATA_W-1:0] r_iload;
    logic [DATA_W-1:0] r_dload;

    ramstate_t         w_rs;
    logic              w_gvalid;
    logic              w_gwrite;
    req_id_t           w_gid;
    logic              w_live;
    logic              w_grant;
    logic              w_read;
    logic [STARVE_W-1:0] w_starve;

    assign w_rs    = ramstate_t'(ramstate);
    assign w_grant = (r_state == IDLE) && w_gvalid;
    assign w_live  = (r_req == REQ_I) ? iREN : (dREN | dWEN);
    assign w_read  = (r_state == IFETCH) || (r_state == DREAD);

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .STARVE_W   (STARVE_W)
    ) u_pick (
        .i_iren   (iREN),
        .i_dren   (dREN),
        .i_dwen   (dWEN),
        .i_starve (w_starve),
        .o_valid  (w_gvalid),
        .o_id     (w_gid),
        .o_write  (w_gwrite)
    );

`ifdef ARB_FAIR_EN
    logic [STARVE_W-1:0] r_starve;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_starve <= '0;
        end else if (w_grant) begin
            if (w_gid == REQ_I)
                r_starve <= '0;
            else if (iREN && r_starve != STARVE_W'(STARVE_MAX))
                r_starve <= r_starve + STARVE_W'(1);
        end
    end

    assign w_starve = r_starve;
`else
    assign w_starve = '0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_gvalid) begin
                    if (w_gid == REQ_I)
                        w_next = IFETCH;
                    else
                        w_next = w_gwrite ? DWRITE : DREAD;
                end
            end
            IFETCH, DREAD, DWRITE: begin
                // a withdrawn request still finishes on the RAM but gets no reply
                if (w_rs == ACCESS)
                    w_next = w_live ? RESP : IDLE;
                else if (w_rs == ERROR)
                    w_next = RETRY;
            end
            RETRY:   w_next = r_acc;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_acc   <= IDLE;
            r_req   <= REQ_I;
            r_addr  <= '0;
            r_store <= '0;
            r_iload <= '0;
            r_dload <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_req   <= w_gid;
                r_acc   <= w_next;
                r_addr  <= (w_gid == REQ_I) ? iaddr : daddr;
                r_store <= dstore;
            end
            if (w_read && w_rs == ACCESS && w_live) begin
                if (r_req == REQ_I)
                    r_iload <= ramload;
                else
                    r_dload <= ramload;
            end
        end
    end

    assign ramREN   = w_read;
    assign ramWEN   = (r_state == DWRITE);
    assign ramaddr  = r_addr;
    assign ramstore = r_store;
    assign iwait    = !((r_state == RESP) && (r_req == REQ_I));
    assign dwait    = !((r_state == RESP) && (r_req == REQ_D));
    assign iload    = r_iload;
    assign dload    = r_dload;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed vector bench for mem_arbiter_ctrl: per-cycle table plus
// hand sequences for asynchronous reset and the grant order under contention.
module tb_mem_arbiter_ctrl;

    localparam logic [1:0] F = 2'd0;
    localparam logic [1:0] B = 2'd1;
    localparam logic [1:0] A = 2'd2;
    localparam logic [1:0] E = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = F;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter_ctrl dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [1:0]  rs;
        logic [31:0] rload;
        logic [4:0]  e_flags;
        logic [31:0] e_addr;
        logic [31:0] e_store;
        logic [31:0] e_iload;
        logic [31:0] e_dload;
    } vec_t;

    vec_t vq[$];

    task automatic add(
        input logic        iren,
        input logic [31:0] ia,
        input logic        dren,
        input logic        dwen,
        input logic [31:0] da,
        input logic [31:0] ds,
        input logic [1:0]  rs,
        input logic [31:0] rl,
        input logic [4:0]  fl,
        input logic [31:0] ea,
        input logic [31:0] es,
        input logic [31:0] ei,
        input logic [31:0] ed
    );
        vec_t v;
        v.iren = iren;  v.iaddr = ia;  v.dren = dren;  v.dwen = dwen;
        v.daddr = da;   v.dstore = ds; v.rs = rs;      v.rload = rl;
        v.e_flags = fl; v.e_addr = ea; v.e_store = es;
        v.e_iload = ei; v.e_dload = ed;
        vq.push_back(v);
    endtask

    // flags = {iwait, dwait, ramREN, ramWEN, busy}
    function automatic logic [132:0] snap();
        return {iwait, dwait, ramREN, ramWEN, busy,
                ramaddr, ramstore, iload, dload};
    endfunction

    task automatic check(input string name, input logic [132:0] act,
                         input logic [132:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got flags=%b addr=%h store=%h iload=%h dload=%h, want flags=%b addr=%h store=%h iload=%h dload=%h",
                     name, act[132:128], act[127:96], act[95:64], act[63:32], act[31:0],
                     exp[132:128], exp[127:96], exp[95:64], exp[63:32], exp[31:0]);
        end
    endtask

    task automatic drive(input vec_t v);
        iREN = v.iren;  iaddr = v.iaddr;
        dREN = v.dren;  dWEN = v.dwen;
        daddr = v.daddr; dstore = v.dstore;
        ramstate = v.rs; ramload = v.rload;
    endtask

    localparam logic [31:0] I1 = 32'h2001_0005;
    localparam logic [31:0] D1 = 32'hAAAA_5555;
    localparam logic [31:0] I2 = 32'h1234_5678;
    localparam logic [31:0] D3 = 32'h0BAD_F00D;
    localparam logic [31:0] WB = 32'hDEAD_BEEF;

    initial begin
        // single fetch
        add(1, 32'h40, 0, 0, 0, 0, F, 0,  5'b11000, 0, 0, 0, 0);
        add(1, 32'h40, 0, 0, 0, 0, A, I1, 5'b11101, 32'h40, 0, 0, 0);
        add(1, 32'h40, 0, 0, 0, 0, F, 0,  5'b01001, 32'h40, 0, I1, 0);
        add(0, 0,      0, 0, 0, 0, F, 0,  5'b11000, 32'h40, 0, I1, 0);
        // collision: data first, then fetch
        add(1, 32'h200, 1, 0, 32'h100, 0, F, 0,  5'b11000, 32'h40,  0, I1, 0);
        add(1, 32'h200, 1, 0, 32'h100, 0, A, D1, 5'b11101, 32'h100, 0, I1, 0);
        add(1, 32'h200, 1, 0, 32'h100, 0, F, 0,  5'b10001, 32'h100, 0, I1, D1);
        add(1, 32'h200, 0, 0, 32'h100, 0, F, 0,  5'b11000, 32'h100, 0, I1, D1);
        add(1, 32'h200, 0, 0, 0, 0, A, I2, 5'b11101, 32'h200, 0, I1, D1);
        add(1, 32'h200, 0, 0, 0, 0, F, 0,  5'b01001, 32'h200, 0, I2, D1);
        add(0, 0,       0, 0, 0, 0, F, 0,  5'b11000, 32'h200, 0, I2, D1);
        // write stalled by BUSY
        add(0, 0, 0, 1, 32'h80, WB, F, 0,    5'b11000, 32'h200, 0,  I2, D1);
        add(0, 0, 0, 1, 32'h80, WB, B, 0,    5'b11011, 32'h80,  WB, I2, D1);
        add(0, 0, 0, 1, 32'h80, WB, B, 0,    5'b11011, 32'h80,  WB, I2, D1);
        add(0, 0, 0, 1, 32'h80, WB, B, 0,    5'b11011, 32'h80,  WB, I2, D1);
        add(0, 0, 0, 1, 32'h80, WB, A, '1,   5'b11011, 32'h80,  WB, I2, D1);
        add(0, 0, 0, 1, 32'h80, WB, F, 0,    5'b10001, 32'h80,  WB, I2, D1);
        add(0, 0, 0, 0, 0, 0,       F, 0,    5'b11000, 32'h80,  WB, I2, D1);
        // read with one ERROR, then retried
        add(0, 0, 1, 0, 32'h44, 0, F, 0,  5'b11000, 32'h80, WB, I2, D1);
        add(0, 0, 1, 0, 32'h44, 0, E, 0,  5'b11101, 32'h44, 0,  I2, D1);
        add(0, 0, 1, 0, 32'h44, 0, F, 0,  5'b11001, 32'h44, 0,  I2, D1);
        add(0, 0, 1, 0, 32'h44, 0, A, D3, 5'b11101, 32'h44, 0,  I2, D1);
        add(0, 0, 1, 0, 32'h44, 0, F, 0,  5'b10001, 32'h44, 0,  I2, D3);
        add(0, 0, 0, 0, 0, 0,      F, 0,  5'b11000, 32'h44, 0,  I2, D3);
        // read withdrawn during the access
        add(0, 0, 1, 0, 32'h60, 0, F, 0,  5'b11000, 32'h44, 0, I2, D3);
        add(0, 0, 0, 0, 32'h60, 0, A, 32'h5555_5555,
                                          5'b11101, 32'h60, 0, I2, D3);
        add(0, 0, 0, 0, 0, 0,      F, 0,  5'b11000, 32'h60, 0, I2, D3);
        add(0, 0, 0, 0, 0, 0,      F, 0,  5'b11000, 32'h60, 0, I2, D3);

        @(negedge CLK);
        check("reset_state", snap(), {5'b11000, 128'h0});
        #2 nRST = 1'b1;

        for (int k = 0; k < vq.size(); k++) begin
            @(posedge CLK);
            #1 drive(vq[k]);
            @(negedge CLK);
            check($sformatf("vec%0d", k), snap(),
                  {vq[k].e_flags, vq[k].e_addr, vq[k].e_store,
                   vq[k].e_iload, vq[k].e_dload});
        end

        // asynchronous reset in the middle of a read
        @(posedge CLK);
        #1;
        iREN = 0; dWEN = 0; ramstate = F;
        dREN = 1; daddr = 32'h70; dstore = 32'h1234;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("dread_before_rst", snap(),
              {5'b11101, 32'h70, 32'h1234, I2, D3});
        #2 nRST = 1'b0;
        #1 check("mid_dread_rst", snap(), {5'b11000, 128'h0});
        dREN = 0;
        @(posedge CLK);
        #1 nRST = 1'b1;

        // contention: both ports hold their requests, RAM always ready
        begin
            logic [31:0] grants[$];
            logic [31:0] want;
            @(posedge CLK);
            #1;
            iREN = 1; iaddr = 32'h300;
            dREN = 1; daddr = 32'h400;
            ramstate = A; ramload = 32'hC0DE_0001;
            for (int c = 0; c < 60 && grants.size() < 5; c++) begin
                @(negedge CLK);
                if (ramREN) grants.push_back(ramaddr);
            end
            iREN = 0; dREN = 0; ramstate = F;
            for (int g = 0; g < 5; g++) begin
`ifdef ARB_FAIR_EN
                want = (g == 4) ? 32'h300 : 32'h400;
`else
                want = 32'h400;
`endif
                n_cmp++;
                if (g >= grants.size()) begin
                    n_bad++;
                    $display("FAIL grant%0d: got no grant in time, want addr %h",
                             g, want);
                end else if (grants[g] !== want) begin
                    n_bad++;
                    $display("FAIL grant%0d: got addr %h, want addr %h",
                             g, grants[g], want);
                end
            end
        end

        repeat (4) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
